// File: rtl/divide_8.sv
// Unsigned 8-bit restoring shift-subtract divider.
// One quotient bit per clock; results held on registered outputs.
module divide_8 (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] Dividend,
    input  logic [7:0] Divisor,
    output logic [7:0] Quotient,
    output logic [7:0] Remainder,
    output logic       Busy,
    output logic       Done,
    output logic       DivZero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] r;
    logic [7:0] q;
    logic [7:0] d;
    logic [2:0] cnt;
    logic [8:0] trial;
    logic [7:0] r_nxt;
    logic [7:0] q_nxt;
    logic       last;

    // Nine-bit trial keeps the borrow; a set MSB means restore.
    always_comb begin
        trial = {r, q[7]} - {1'b0, d};
        if (!trial[8]) begin
            r_nxt = trial[7:0];
            q_nxt = {q[6:0], 1'b1};
        end else begin
            r_nxt = {r[6:0], q[7]};
            q_nxt = {q[6:0], 1'b0};
        end
    end

    assign last = (cnt == 3'd7);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (Start) state_nxt = CALC;
            CALC: if (last) state_nxt = DONE;
            DONE: if (!Start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r         <= 8'd0;
            q         <= 8'd0;
            d         <= 8'd0;
            cnt       <= 3'd0;
            Quotient  <= 8'd0;
            Remainder <= 8'd0;
            DivZero   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        q   <= Dividend;
                        d   <= Divisor;
                        r   <= 8'd0;
                        cnt <= 3'd0;
                    end
                end
                CALC: begin
                    r   <= r_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + 3'd1;
                    if (last) begin
                        Quotient  <= q_nxt;
                        Remainder <= r_nxt;
                        DivZero   <= (d == 8'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state == CALC);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_divide_8.sv
// Randomized self-checking bench for divide_8.
// Expected results come from plain integer division.
module tb_divide_8;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic [7:0] Dividend;
    logic [7:0] Divisor;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       DivZero;

    int         checks;
    int         errors;
    logic [7:0] prev_q;
    logic [7:0] prev_r;

    divide_8 dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .Busy     (Busy),
        .Done     (Done),
        .DivZero  (DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] a,
                         input logic [7:0] b,
                         input bit hold,
                         input bit disturb);
        int         n;
        logic [7:0] eq;
        logic [7:0] er;
        logic       ez;
        ez = (b == 8'd0);
        eq = ez ? 8'hFF : 8'(a / b);
        er = ez ? a : 8'(a % b);
        @(negedge Clk);
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        @(posedge Clk);
        #1;
        check("busy_start", Busy, 1);
        check("q_held", Quotient, prev_q);
        check("r_held", Remainder, prev_r);
        n = 0;
        while (!Done && n < 20) begin
            @(negedge Clk);
            if (!hold) Start = 1'b0;
            if (disturb && n == 3) begin
                Dividend = 8'd9;
                Divisor  = 8'd2;
                Start    = 1'b1;
            end
            if (disturb && n == 4) Start = 1'b0;
            @(posedge Clk);
            #1;
            n++;
        end
        check("latency", n, 8);
        check("quotient", Quotient, eq);
        check("remainder", Remainder, er);
        check("divzero", DivZero, ez);
        check("busy_done", Busy, 0);
        prev_q = eq;
        prev_r = er;
        if (!hold) begin
            @(posedge Clk);
            #1;
            check("idle_done", Done, 0);
            check("idle_busy", Busy, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         bad;
        logic [7:0] a;
        logic [7:0] b;
        checks   = 0;
        errors   = 0;
        prev_q   = 8'd0;
        prev_r   = 8'd0;
        Reset    = 1'b0;
        Start    = 1'b0;
        Dividend = 8'd0;
        Divisor  = 8'd0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_q", Quotient, 0);
        check("rst_r", Remainder, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_dz", DivZero, 0);
        @(negedge Clk);
        Reset = 1'b1;

        do_op(8'd200, 8'd7, 0, 0);
        do_op(8'd255, 8'd1, 0, 0);
        do_op(8'd5, 8'd9, 0, 0);
        do_op(8'd255, 8'd255, 0, 0);
        do_op(8'd100, 8'd0, 0, 0);
        do_op(8'd100, 8'd10, 0, 0);
        do_op(8'd200, 8'd7, 0, 1);

        do_op(8'd200, 8'd7, 1, 0);
        bad = 0;
        repeat (20) begin
            @(posedge Clk);
            #1;
            if (!Done || Busy) bad++;
        end
        check("hold_done", bad, 0);
        @(negedge Clk);
        Start = 1'b0;
        do_op(8'd17, 8'd4, 0, 0);

        @(negedge Clk);
        Dividend = 8'd200;
        Divisor  = 8'd7;
        Start    = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("mid_rst_q", Quotient, 0);
        check("mid_rst_r", Remainder, 0);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_done", Done, 0);
        check("mid_rst_dz", DivZero, 0);
        prev_q = 8'd0;
        prev_r = 8'd0;
        @(negedge Clk);
        Reset = 1'b1;
        do_op(8'd81, 8'd9, 0, 0);

        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            do_op(a, b, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
